ex_mem_branch_stage: RTL and testbench

- Sits directly downstream of the 32-bit ALU in the 5-stage pipelined RV32I core.
- Consumes the ALU result and flags (cf, zf, vf, sf) and resolves conditional branches and JAL/JALR.
- Registers the EX/MEM pipeline boundary and issues a registered PC redirect plus a flush of the younger stages.
- Supports MEM-stage stall (hold) and self-kill of the wrong-path instruction that follows a taken redirect.

---
 rtl/ex_mem_branch_stage_pkg.sv | 17 +
 rtl/ex_mem_branch_stage_branch_cond_unit.sv | 28 ++
 rtl/ex_mem_branch_stage.sv | 114 +++++++++++
 tb/tb_ex_mem_branch_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_branch_stage_pkg.sv
// Shared constants for the EX/MEM branch stage: widths, bubble rd, branch funct3 codes.
package ex_mem_branch_stage_pkg;

  localparam int          XLEN   = 32;
  localparam logic [4:0]  NOP_RD = 5'd0;

  // RV32I conditional-branch funct3 encodings; 010/011 are unused and never taken.
  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_funct3_e;

endpackage

// File: rtl/ex_mem_branch_stage_branch_cond_unit.sv
// Branch condition decode from ALU flags. The ALU runs SUB (a-b) for branches;
// cf follows the no-borrow convention, so cf=1 means a >= b unsigned.
module branch_cond_unit
  import ex_mem_branch_stage_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_cf,
  input  logic       i_zf,
  input  logic       i_vf,
  input  logic       i_sf,
  output logic       o_cond
);

  // Select the condition; unused encodings resolve to not-taken.
  always_comb begin
    o_cond = 1'b0;
    case (i_funct3)
      BR_BEQ:  o_cond = i_zf;
      BR_BNE:  o_cond = ~i_zf;
      BR_BLT:  o_cond = i_sf ^ i_vf;
      BR_BGE:  o_cond = ~(i_sf ^ i_vf);
      BR_BLTU: o_cond = ~i_cf;
      BR_BGEU: o_cond = i_cf;
      default: o_cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_branch_stage.sv
// EX/MEM pipeline register with branch/JAL/JALR resolution, registered PC
// redirect, wrong-path self-kill and MEM-stall hold.
module ex_mem_branch_stage
  import ex_mem_branch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_pc_plus4,
  input  logic [XLEN-1:0] ex_br_target,
  input  logic [XLEN-1:0] ex_alu_r,
  input  logic            ex_cf,
  input  logic            ex_zf,
  input  logic            ex_vf,
  input  logic            ex_sf,
  input  logic            ex_branch,
  input  logic            ex_jal,
  input  logic            ex_jalr,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic [4:0]      ex_rd,
  input  logic            ex_regwrite,
  input  logic            ex_memread,
  input  logic            ex_memwrite,
  input  logic            ex_memtoreg,
  input  logic            mem_stall,
  output logic            mem_valid,
  output logic [XLEN-1:0] mem_result,
  output logic [XLEN-1:0] mem_store_data,
  output logic [4:0]      mem_rd,
  output logic            mem_regwrite,
  output logic            mem_memread,
  output logic            mem_memwrite,
  output logic            mem_memtoreg,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            misalign_exc
);

  logic            r_valid, r_regwrite, r_memread, r_memwrite, r_memtoreg;
  logic            r_redirect_valid, r_misalign;
  logic [XLEN-1:0] r_result, r_store_data, r_redirect_pc;
  logic [4:0]      r_rd;

  logic            w_cond, w_live, w_take, w_mis, w_keep, w_link;
  logic [XLEN-1:0] w_tgt, w_result;

  // The EX PC is carried for debug visibility upstream; nothing here needs it.
  logic            w_unused_pc;
  assign w_unused_pc = ^ex_pc;

  branch_cond_unit u_cond (
    .i_funct3 (ex_funct3),
    .i_cf     (ex_cf),
    .i_zf     (ex_zf),
    .i_vf     (ex_vf),
    .i_sf     (ex_sf),
    .o_cond   (w_cond)
  );

  // The slot right behind a registered redirect is wrong-path: kill it here.
  assign w_live   = ex_valid & ~r_redirect_valid;
  assign w_link   = ex_jal | ex_jalr;
  assign w_take   = w_live & (w_link | (ex_branch & w_cond));
  assign w_tgt    = ex_jalr ? {ex_alu_r[XLEN-1:1], 1'b0} : ex_br_target;
  assign w_result = w_link ? ex_pc_plus4 : ex_alu_r;
  // A taken jump to a non-word-aligned target traps instead of redirecting and
  // retires nothing, so it enters MEM as a bubble.
  assign w_mis    = w_take & w_tgt[1];
  assign w_keep   = w_live & ~w_mis;

  // EX/MEM boundary: reset clears, stall holds everything including the redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid          <= 1'b0;
      r_result         <= '0;
      r_store_data     <= '0;
      r_rd             <= NOP_RD;
      r_regwrite       <= 1'b0;
      r_memread        <= 1'b0;
      r_memwrite       <= 1'b0;
      r_memtoreg       <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_misalign       <= 1'b0;
    end else if (!mem_stall) begin
      r_valid          <= w_keep;
      r_result         <= w_result;
      r_store_data     <= ex_rs2_data;
      r_rd             <= w_keep ? ex_rd : NOP_RD;
      r_regwrite       <= ex_regwrite & w_keep;
      r_memread        <= ex_memread  & w_keep;
      r_memwrite       <= ex_memwrite & w_keep;
      r_memtoreg       <= ex_memtoreg & w_keep;
      r_redirect_valid <= w_take & ~w_tgt[1];
      r_redirect_pc    <= w_tgt;
      r_misalign       <= w_mis;
    end
  end

  assign mem_valid      = r_valid;
  assign mem_result     = r_result;
  assign mem_store_data = r_store_data;
  assign mem_rd         = r_rd;
  assign mem_regwrite   = r_regwrite;
  assign mem_memread    = r_memread;
  assign mem_memwrite   = r_memwrite;
  assign mem_memtoreg   = r_memtoreg;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign misalign_exc   = r_misalign;

endmodule

// File: tb/tb_ex_mem_branch_stage.sv
// Directed bench for ex_mem_branch_stage with hand-computed expectations.
module tb_ex_mem_branch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_pc_plus4, ex_br_target, ex_alu_r, ex_rs2_data;
  logic        ex_cf, ex_zf, ex_vf, ex_sf;
  logic        ex_branch, ex_jal, ex_jalr;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
  logic        mem_stall;
  logic        mem_valid;
  logic [31:0] mem_result, mem_store_data, redirect_pc;
  logic [4:0]  mem_rd;
  logic        mem_regwrite, mem_memread, mem_memwrite, mem_memtoreg;
  logic        redirect_valid, misalign_exc;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_mem_branch_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pc_plus4(ex_pc_plus4),
    .ex_br_target(ex_br_target), .ex_alu_r(ex_alu_r),
    .ex_cf(ex_cf), .ex_zf(ex_zf), .ex_vf(ex_vf), .ex_sf(ex_sf),
    .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
    .ex_funct3(ex_funct3), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
    .mem_stall(mem_stall),
    .mem_valid(mem_valid), .mem_result(mem_result),
    .mem_store_data(mem_store_data), .mem_rd(mem_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .mem_memtoreg(mem_memtoreg),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .misalign_exc(misalign_exc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_clear();
    ex_valid = 0; ex_pc = 0; ex_pc_plus4 = 0; ex_br_target = 0; ex_alu_r = 0;
    ex_rs2_data = 0; ex_cf = 0; ex_zf = 0; ex_vf = 0; ex_sf = 0;
    ex_branch = 0; ex_jal = 0; ex_jalr = 0; ex_funct3 = 0; ex_rd = 0;
    ex_regwrite = 0; ex_memread = 0; ex_memwrite = 0; ex_memtoreg = 0;
  endtask

  task automatic ex_br(input logic [2:0] f3, input logic cf, input logic zf,
                       input logic vf, input logic sf, input logic [31:0] tgt);
    ex_clear();
    ex_valid = 1; ex_branch = 1; ex_funct3 = f3;
    ex_cf = cf; ex_zf = zf; ex_vf = vf; ex_sf = sf; ex_br_target = tgt;
  endtask

  task automatic ex_add(input logic [4:0] rd, input logic [31:0] r);
    ex_clear();
    ex_valid = 1; ex_regwrite = 1; ex_rd = rd; ex_alu_r = r;
  endtask

  initial begin
    ex_clear();
    mem_stall = 0;
    rst = 1;
    tick(); tick();
    chk("rst_valid", {31'd0, mem_valid}, 0);
    chk("rst_rd", {27'd0, mem_rd}, 0);
    chk("rst_redir", {31'd0, redirect_valid}, 0);
    chk("rst_result", mem_result, 0);
    chk("rst_mis", {31'd0, misalign_exc}, 0);
    rst = 0;

    // BEQ taken, then a wrong-path ADD, then a normal ADD
    ex_br(3'b000, 1, 1, 0, 0, 32'h100);
    tick();
    chk("beq_redir", {31'd0, redirect_valid}, 1);
    chk("beq_pc", redirect_pc, 32'h100);
    chk("beq_valid", {31'd0, mem_valid}, 1);
    chk("beq_rw", {31'd0, mem_regwrite}, 0);
    ex_add(5'd7, 32'h55);
    tick();
    chk("kill_valid", {31'd0, mem_valid}, 0);
    chk("kill_rw", {31'd0, mem_regwrite}, 0);
    chk("kill_rd", {27'd0, mem_rd}, 0);
    chk("kill_redir", {31'd0, redirect_valid}, 0);
    ex_add(5'd8, 32'h66);
    tick();
    chk("add3_valid", {31'd0, mem_valid}, 1);
    chk("add3_rw", {31'd0, mem_regwrite}, 1);
    chk("add3_rd", {27'd0, mem_rd}, 8);
    chk("add3_res", mem_result, 32'h66);

    // BLTU 1 < 0xFFFFFFFF (cf=0) taken
    ex_br(3'b110, 0, 0, 0, 0, 32'h200);
    tick();
    chk("bltu_redir", {31'd0, redirect_valid}, 1);
    chk("bltu_pc", redirect_pc, 32'h200);
    ex_clear();
    tick();
    chk("bub_valid", {31'd0, mem_valid}, 0);
    chk("bub_redir", {31'd0, redirect_valid}, 0);
    // BGE -1 >= 1 is false (sf=1, vf=0)
    ex_br(3'b101, 0, 0, 0, 1, 32'h300);
    tick();
    chk("bge_redir", {31'd0, redirect_valid}, 0);
    chk("bge_valid", {31'd0, mem_valid}, 1);
    chk("bge_rw", {31'd0, mem_regwrite}, 0);
    chk("bge_mw", {31'd0, mem_memwrite}, 0);
    // Reserved funct3 with branch set is never taken
    ex_br(3'b010, 1, 1, 1, 1, 32'h340);
    tick();
    chk("f010_redir", {31'd0, redirect_valid}, 0);

    // JALR aligned: 0x2001 -> 0x2000
    ex_clear();
    ex_valid = 1; ex_jalr = 1; ex_alu_r = 32'h2001; ex_pc_plus4 = 32'h44;
    ex_rd = 5; ex_regwrite = 1;
    tick();
    chk("jalr_redir", {31'd0, redirect_valid}, 1);
    chk("jalr_pc", redirect_pc, 32'h2000);
    chk("jalr_res", mem_result, 32'h44);
    chk("jalr_rd", {27'd0, mem_rd}, 5);
    chk("jalr_rw", {31'd0, mem_regwrite}, 1);
    chk("jalr_mis", {31'd0, misalign_exc}, 0);
    ex_clear();
    tick();
    // JALR 0x2003 -> 0x2002: bit1 set, trap
    ex_valid = 1; ex_jalr = 1; ex_alu_r = 32'h2003; ex_pc_plus4 = 32'h48;
    ex_rd = 5; ex_regwrite = 1;
    tick();
    chk("mis_exc", {31'd0, misalign_exc}, 1);
    chk("mis_redir", {31'd0, redirect_valid}, 0);
    chk("mis_rw", {31'd0, mem_regwrite}, 0);
    // JAL right after the trap is not killed (no redirect happened)
    ex_clear();
    ex_valid = 1; ex_jal = 1; ex_br_target = 32'h400; ex_pc_plus4 = 32'h80;
    ex_rd = 1; ex_regwrite = 1;
    tick();
    chk("jal_redir", {31'd0, redirect_valid}, 1);
    chk("jal_pc", redirect_pc, 32'h400);
    chk("jal_res", mem_result, 32'h80);
    chk("jal_mis", {31'd0, misalign_exc}, 0);
    ex_clear();
    tick();

    // Taken branch then 3 stall cycles
    ex_br(3'b001, 0, 0, 0, 0, 32'h500);
    ex_rd = 3; ex_alu_r = 32'h11;
    tick();
    chk("st_redir0", {31'd0, redirect_valid}, 1);
    ex_add(5'd9, 32'h77);
    mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_redir", {31'd0, redirect_valid}, 1);
      chk("st_pc", redirect_pc, 32'h500);
      chk("st_valid", {31'd0, mem_valid}, 1);
      chk("st_rd", {27'd0, mem_rd}, 3);
      chk("st_res", mem_result, 32'h11);
    end
    mem_stall = 0;
    tick();
    chk("rel_valid", {31'd0, mem_valid}, 0);
    chk("rel_rw", {31'd0, mem_regwrite}, 0);
    chk("rel_rd", {27'd0, mem_rd}, 0);
    chk("rel_redir", {31'd0, redirect_valid}, 0);
    chk("rel_res", mem_result, 32'h77);

    // Reset while redirecting and stalled
    ex_br(3'b000, 0, 1, 0, 0, 32'h600);
    ex_rd = 4; ex_alu_r = 32'h22; ex_rs2_data = 32'h33;
    tick();
    chk("pre_redir", {31'd0, redirect_valid}, 1);
    mem_stall = 1; rst = 1;
    tick();
    chk("mr_redir", {31'd0, redirect_valid}, 0);
    chk("mr_pc", redirect_pc, 0);
    chk("mr_valid", {31'd0, mem_valid}, 0);
    chk("mr_rd", {27'd0, mem_rd}, 0);
    chk("mr_res", mem_result, 0);
    chk("mr_sd", mem_store_data, 0);
    rst = 0; mem_stall = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
